// File: rtl/intra_pkg.sv
// intra_pkg: shared constants, descriptor layout and TB cycle-count helper for the intra TB sequencer
package intra_pkg;
  localparam int INTRA_LOG2_MIN = 2;
  localparam int INTRA_LOG2_MAX = 5;
  localparam int DESC_W = 12;
  typedef enum logic [1:0] {
    INTRA_CIDX_Y  = 2'd0,
    INTRA_CIDX_CB = 2'd1,
    INTRA_CIDX_CR = 2'd2
  } cidx_e;
  typedef struct packed {
    logic [2:0] log2size;
    logic       chroma;
    logic [5:0] mode;
    logic       in64;
    logic       q3;
  } desc_t;
  function automatic logic [6:0] tb_cycles(input logic [2:0] log2size, input int log2ppc);
    int sh;
    sh = 2 * int'(log2size) - log2ppc;
    return (sh <= 0) ? 7'd1 : 7'(1 << sh);
  endfunction
endpackage

// File: rtl/intra_desc_fifo.sv
// intra_desc_fifo: DEPTH-entry descriptor FIFO with registered storage and count-based full/empty
module intra_desc_fifo
  import intra_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  arst_n,
  input  logic  clr,
  input  logic  push,
  input  logic  pop,
  input  desc_t din,
  output desc_t dout,
  output logic  full,
  output logic  empty
);
  localparam int AW = $clog2(DEPTH);
  desc_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  // pointers and occupancy; a simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // descriptor storage, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
  assign dout  = mem[rd_ptr];
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/intra_tb_seq.sv
// intra_tb_seq: TB descriptor sequencer and per-TB cycle counter feeding intra stall control; INTRA_TBSEQ_STAT_EN adds pop/stall statistics
module intra_tb_seq
  import intra_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int LOG2_PPC = 4
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       flush,
  input  logic       desc_val,
  output logic       desc_rdy,
  input  logic [2:0] desc_log2size,
  input  logic [1:0] desc_cidx,
  input  logic [5:0] desc_mode,
  input  logic       desc_in64,
  input  logic       desc_q3,
  output logic       cabad_intra_val,
  input  logic       cabad_intra_rdy,
  input  logic       resi_val,
  input  logic       bStop,
  output logic       isLastCycInTb,
  output logic       cIdx,
  output logic       isLast32In64_inter,
  output logic       tb_busy,
  output logic [5:0] tb_mode,
  output logic [2:0] tb_log2size
`ifdef INTRA_TBSEQ_STAT_EN
  ,
  output logic [15:0] stat_tb_cnt,
  output logic [15:0] stat_stall_cnt
`endif
);
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       adv;
  logic       last;
  logic [6:0] total;
  logic [5:0] cyc_cnt;
  desc_t      din;
  desc_t      head;
  desc_t      tb;
  assign push  = desc_val && !full && !flush;
  assign pop   = !empty && cabad_intra_rdy && !flush;
  assign din   = '{log2size: desc_log2size, chroma: desc_cidx != INTRA_CIDX_Y,
                   mode: desc_mode, in64: desc_in64, q3: desc_q3};
  assign total = tb_cycles(tb.log2size, LOG2_PPC);
  assign last  = tb_busy && cyc_cnt == 6'(total - 7'd1);
  assign adv   = tb_busy && resi_val && !bStop;
  intra_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .arst_n(arst_n),
    .clr   (flush),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  // active TB: a pop always wins, so a new TB loads back-to-back over the finishing one
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tb_busy <= 1'b0;
      cyc_cnt <= '0;
      tb      <= '0;
    end else if (flush) begin
      tb_busy <= 1'b0;
      cyc_cnt <= '0;
      tb      <= '0;
    end else if (pop) begin
      tb_busy <= 1'b1;
      cyc_cnt <= '0;
      tb      <= head;
    end else if (adv) begin
      cyc_cnt <= last ? '0 : cyc_cnt + 6'd1;
      if (last) tb_busy <= 1'b0;
    end
  end
`ifdef INTRA_TBSEQ_STAT_EN
  // saturating pop and stall-cycle statistics
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stat_tb_cnt    <= '0;
      stat_stall_cnt <= '0;
    end else if (flush) begin
      stat_tb_cnt    <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (pop && stat_tb_cnt != '1) stat_tb_cnt <= stat_tb_cnt + 16'd1;
      if (tb_busy && resi_val && bStop && stat_stall_cnt != '1) stat_stall_cnt <= stat_stall_cnt + 16'd1;
    end
  end
`endif
  assign desc_rdy           = arst_n && !full;
  assign cabad_intra_val    = !empty;
  assign isLastCycInTb      = last;
  assign cIdx               = tb_busy && tb.chroma;
  assign isLast32In64_inter = tb_busy && (!tb.in64 || tb.q3);
  assign tb_mode            = tb_busy ? tb.mode : '0;
  assign tb_log2size        = tb_busy ? tb.log2size : '0;
  log2size_range: assert property (@(posedge clk) disable iff (!arst_n)
    desc_val |-> (desc_log2size >= 3'(INTRA_LOG2_MIN) && desc_log2size <= 3'(INTRA_LOG2_MAX)));
endmodule

// File: tb/tb_intra_tb_seq.sv
// tb_intra_tb_seq: directed scenarios plus randomized traffic checked every cycle against a queue-based model
module tb_intra_tb_seq;
  logic       clk = 0;
  logic       arst_n = 0;
  logic       flush = 0;
  logic       desc_val = 0;
  logic       desc_rdy;
  logic [2:0] desc_log2size = 3'd2;
  logic [1:0] desc_cidx = 0;
  logic [5:0] desc_mode = 0;
  logic       desc_in64 = 0;
  logic       desc_q3 = 0;
  logic       cabad_intra_val;
  logic       cabad_intra_rdy = 0;
  logic       resi_val = 0;
  logic       bStop = 0;
  logic       isLastCycInTb;
  logic       cIdx;
  logic       isLast32In64_inter;
  logic       tb_busy;
  logic [5:0] tb_mode;
  logic [2:0] tb_log2size;
`ifdef INTRA_TBSEQ_STAT_EN
  logic [15:0] stat_tb_cnt;
  logic [15:0] stat_stall_cnt;
`endif
  intra_tb_seq dut (
    .clk(clk), .arst_n(arst_n), .flush(flush), .desc_val(desc_val), .desc_rdy(desc_rdy),
    .desc_log2size(desc_log2size), .desc_cidx(desc_cidx), .desc_mode(desc_mode),
    .desc_in64(desc_in64), .desc_q3(desc_q3), .cabad_intra_val(cabad_intra_val),
    .cabad_intra_rdy(cabad_intra_rdy), .resi_val(resi_val), .bStop(bStop),
    .isLastCycInTb(isLastCycInTb), .cIdx(cIdx), .isLast32In64_inter(isLast32In64_inter),
    .tb_busy(tb_busy), .tb_mode(tb_mode), .tb_log2size(tb_log2size)
`ifdef INTRA_TBSEQ_STAT_EN
    , .stat_tb_cnt(stat_tb_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    int l;
    bit ch;
    int mode;
    bit in64;
    bit q3;
  } d_t;
  d_t q[$];
  d_t cur;
  bit busy;
  int rem;
  int n_tb;
  int n_stall;
  int checks = 0;
  int failures = 0;
  function automatic int cycles_of(int l);
    int s;
    s = (1 << (2 * l)) / 16;
    return s < 1 ? 1 : s;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic compare();
    chk("desc_rdy", desc_rdy, arst_n && q.size() < 4);
    chk("cabad_intra_val", cabad_intra_val, q.size() > 0);
    chk("tb_busy", tb_busy, busy);
    chk("isLastCycInTb", isLastCycInTb, busy && rem == 1);
    chk("cIdx", cIdx, busy && cur.ch);
    chk("isLast32In64_inter", isLast32In64_inter, busy && (!cur.in64 || cur.q3));
    chk("tb_mode", tb_mode, busy ? cur.mode : 0);
    chk("tb_log2size", tb_log2size, busy ? cur.l : 0);
`ifdef INTRA_TBSEQ_STAT_EN
    chk("stat_tb_cnt", stat_tb_cnt, n_tb);
    chk("stat_stall_cnt", stat_stall_cnt, n_stall);
`endif
  endtask
  task automatic model_edge();
    bit pu, po, st, ad;
    if (!arst_n || flush) begin
      q.delete();
      busy = 0;
      rem = 0;
      n_tb = 0;
      n_stall = 0;
      return;
    end
    pu = desc_val && q.size() < 4;
    po = q.size() > 0 && cabad_intra_rdy;
    st = busy && resi_val && bStop;
    ad = busy && resi_val && !bStop;
    if (st && n_stall < 65535) n_stall++;
    if (po) begin
      cur = q.pop_front();
      busy = 1;
      rem = cycles_of(cur.l);
      if (n_tb < 65535) n_tb++;
    end else if (ad) begin
      rem--;
      if (rem == 0) busy = 0;
    end
    if (pu) q.push_back('{int'(desc_log2size), desc_cidx != 0, int'(desc_mode), desc_in64, desc_q3});
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask
  task automatic push_desc(input int l, input int c, input int m, input bit i64, input bit q3);
    desc_log2size = 3'(l);
    desc_cidx = 2'(c);
    desc_mode = 6'(m);
    desc_in64 = i64;
    desc_q3 = q3;
    desc_val = 1;
    tick();
    desc_val = 0;
    desc_log2size = 3'd2;
  endtask
  task automatic pop1();
    cabad_intra_rdy = 1;
    tick();
    cabad_intra_rdy = 0;
  endtask
  task automatic wait_last(input int k0, output int k);
    k = 0;
    for (int i = k0; i < k0 + 200; i++) begin
      if (isLastCycInTb) begin
        k = i;
        break;
      end
      tick();
    end
  endtask
  task automatic do_flush();
    flush = 1;
    tick();
    flush = 0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    int k;
    tick();
    tick();
    chk("rst_busy", tb_busy, 0);
    chk("rst_val", cabad_intra_val, 0);
    chk("rst_rdy_in_reset", desc_rdy, 0);
    arst_n = 1;
    #1;
    chk("rst_rdy_released", desc_rdy, 1);
    // 1: single 8x8 luma TB
    resi_val = 1;
    push_desc(3, 0, 26, 0, 0);
    pop1();
    chk("t1_mode", tb_mode, 26);
    wait_last(1, k);
    chk("t1_last_cyc", k, 4);
    tick();
    chk("t1_idle", tb_busy, 0);
    // 2: fill FIFO, held fifth descriptor
    resi_val = 0;
    for (int i = 0; i < 4; i++) push_desc(3, i % 3, i + 1, 0, 0);
    chk("t2_full", desc_rdy, 0);
    desc_log2size = 3'd4;
    desc_mode = 6'd9;
    desc_val = 1;
    cabad_intra_rdy = 1;
    tick();
    cabad_intra_rdy = 0;
    chk("t2_rdy_after_pop", desc_rdy, 1);
    tick();
    desc_val = 0;
    desc_log2size = 3'd2;
    chk("t2_full_again", desc_rdy, 0);
    do_flush();
    // 3: 32x32 TB with a 10-cycle stall
    resi_val = 1;
    push_desc(5, 0, 10, 0, 0);
    pop1();
    for (int i = 0; i < 20; i++) tick();
    bStop = 1;
    for (int i = 0; i < 10; i++) tick();
    bStop = 0;
    wait_last(31, k);
    chk("t3_last_cyc", k, 74);
`ifdef INTRA_TBSEQ_STAT_EN
    chk("t3_stall_cnt", stat_stall_cnt, 10);
`endif
    tick();
    do_flush();
    // 4: back-to-back 4x4 Cb TBs
    push_desc(2, 1, 5, 0, 0);
    push_desc(2, 1, 6, 0, 0);
    cabad_intra_rdy = 1;
    tick();
    chk("t4_last_a", isLastCycInTb, 1);
    chk("t4_cidx_a", cIdx, 1);
    tick();
    chk("t4_last_b", isLastCycInTb, 1);
    chk("t4_cidx_b", cIdx, 1);
    chk("t4_mode_b", tb_mode, 6);
    cabad_intra_rdy = 0;
    tick();
    chk("t4_last_c", isLastCycInTb, 0);
    // 5: 64x64 quadrant flag
    push_desc(2, 0, 1, 1, 0);
    push_desc(2, 0, 2, 1, 1);
    push_desc(2, 0, 3, 0, 0);
    cabad_intra_rdy = 1;
    tick();
    chk("t5_in64_q0", isLast32In64_inter, 0);
    tick();
    chk("t5_in64_q3", isLast32In64_inter, 1);
    tick();
    chk("t5_not64", isLast32In64_inter, 1);
    cabad_intra_rdy = 0;
    tick();
    // 6: flush mid-TB with entries queued
    resi_val = 0;
    push_desc(3, 2, 7, 0, 0);
    pop1();
    for (int i = 0; i < 3; i++) push_desc(4, 0, i, 0, 0);
    chk("t6_busy_before", tb_busy, 1);
    do_flush();
    chk("t6_busy", tb_busy, 0);
    chk("t6_val", cabad_intra_val, 0);
    chk("t6_rdy", desc_rdy, 1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      desc_val = 1'($urandom % 2);
      desc_log2size = 3'(2 + $urandom % 4);
      desc_cidx = 2'($urandom % 3);
      desc_mode = 6'($urandom % 35);
      desc_in64 = 1'($urandom % 2);
      desc_q3 = 1'($urandom % 2);
      cabad_intra_rdy = ($urandom % 4) == 0;
      resi_val = ($urandom % 4) != 0;
      bStop = ($urandom % 5) == 0;
      flush = ($urandom % 300) == 0;
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
